// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: state enum, opcode
// classes and the ALU mux/operation select values.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_EXEC_R,
        ST_ALU_WB,
        ST_BRANCH,
        ST_TRAP
    } state_e;

    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_class.sv
// Classifies the decoded opcode bits into one-hot instruction classes;
// anything outside the supported subset raises is_bad_o.
module opcode_class
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       is_r_o,
    output logic       is_ld_o,
    output logic       is_st_o,
    output logic       is_br_o,
    output logic       is_bad_o
);

    always_comb begin
        is_r_o   = (opcode_i == OP_RTYPE);
        is_ld_o  = (opcode_i == OP_LOAD);
        is_st_o  = (opcode_i == OP_STORE);
        is_br_o  = (opcode_i == OP_BRANCH);
        is_bad_o = !(is_r_o || is_ld_o || is_st_o || is_br_o);
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the R-type/lw/sw/beq datapath: steps through
// fetch, decode and execute phases, stalling on the memory ready handshake.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] inst,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_src,
    output logic       illegal,
    output logic       retire
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   is_r, is_ld, is_st, is_br, is_bad;
    logic   unused_inst_bits;

    assign unused_inst_bits = ^inst[1:0];

    opcode_class u_opcode_class (
        .opcode_i (inst[6:2]),
        .is_r_o   (is_r),
        .is_ld_o  (is_ld),
        .is_st_o  (is_st),
        .is_br_o  (is_br),
        .is_bad_o (is_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_r)                state_d = ST_EXEC_R;
                else if (is_ld || is_st) state_d = ST_MEM_ADDR;
                else if (is_br)          state_d = ST_BRANCH;
                else                     state_d = ST_TRAP;
                if (is_bad) illegal_d = 1'b1;
            end
            // inst is held stable by the IR, so this cannot miss; TRAP is a safe fallback.
            ST_MEM_ADDR: begin
                if (is_ld)      state_d = ST_MEM_RD;
                else if (is_st) state_d = ST_MEM_WR;
                else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:   state_d = ST_ALU_WB;
            ST_ALU_WB:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    // rst gates every output so nothing is written on the reset cycle.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            illegal = illegal_q;
            unique case (state_q)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                ST_ALU_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_SUB;
                    pc_src    = 1'b1;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                ST_TRAP: begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
